// File: rtl/pwm_capture.sv
// PWM capture: synchronises pwm_in, measures high time and period per PWM cycle,
// hands out one result per period over valid/ready. Define PWM_CAP_FILTER_EN to add a glitch filter.
module pwm_capture #(
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = 1000000,
  parameter int FILT_LEN = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun,
  output logic             timeout,
  output logic             stuck_level
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS} state_e;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             lvl_d_q, lvl_d_d;
  logic             lvl, rise;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             tmo_q, tmo_d;
  logic             stuck_q, stuck_d;

  // A zero-length filter is meaningless; keep the parameter referenced in every build.
  if (FILT_LEN < 1) begin : g_filt_len_invalid
  end

  always_comb begin
    sync1_d = pwm_in;
    sync2_d = sync1_q;
    lvl_d_d = lvl;
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // fcnt counts consecutive cycles the synchronised input disagrees with the filtered level.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FW'(FILT_LEN - 1)) filt_d = sync2_q;
      else                             fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  assign rise = lvl & ~lvl_d_q;

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    high_d   = high_q;
    period_d = period_q;
    valid_d  = valid_q & ~meas_ready;
    ovr_d    = ovr_q;
    tmo_d    = tmo_q;
    stuck_d  = stuck_q;
    if (!en) begin
      state_d = IDLE;
      pcnt_d  = '0;
      hcnt_d  = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
      tmo_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pcnt_d  = '0;
          hcnt_d  = '0;
          state_d = WAIT_RISE;
        end
        // pcnt doubles as the since-enable counter while waiting for the first rise.
        WAIT_RISE: begin
          if (rise) begin
            state_d = MEAS;
            pcnt_d  = CNT_W'(1);
            hcnt_d  = CNT_W'(1);
          end else if (pcnt_q == TMO) begin
            tmo_d   = 1'b1;
            stuck_d = lvl;
            pcnt_d  = '0;
            hcnt_d  = '0;
          end else begin
            pcnt_d  = pcnt_q + 1'b1;
          end
        end
        MEAS: begin
          if (rise) begin
            high_d   = hcnt_q;
            period_d = pcnt_q;
            valid_d  = 1'b1;
            tmo_d    = 1'b0;
            if (valid_q && !meas_ready) ovr_d = 1'b1;
            pcnt_d   = CNT_W'(1);
            hcnt_d   = CNT_W'(1);
          end else if (pcnt_q == TMO) begin
            tmo_d   = 1'b1;
            stuck_d = lvl;
            state_d = WAIT_RISE;
            pcnt_d  = '0;
            hcnt_d  = '0;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
            hcnt_d = hcnt_q + CNT_W'(lvl);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      lvl_d_q  <= 1'b0;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      tmo_q    <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      lvl_d_q  <= lvl_d_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      high_q   <= high_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      tmo_q    <= tmo_d;
      stuck_q  <= stuck_d;
    end
  end

  assign high_cnt    = high_q;
  assign period_cnt  = period_q;
  assign meas_valid  = valid_q;
  assign overrun     = ovr_q;
  assign timeout     = tmo_q;
  assign stuck_level = stuck_q;

endmodule
